// File: rtl/rt_pixel_dispatcher.sv
// rt_pixel_dispatcher
// Frame sequencer in front of RTcore: walks the raster row-major, fires one
// RT_ENABLE per pixel, waits for the rendered pixel and pushes it to the
// framebuffer over a valid/ready write port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no frame in progress, waiting for START
// ISSUE   | one-cycle RT_ENABLE pulse for the current (X,Y)
// WAIT    | waiting for RT_READY; first cycle is a blanking cycle
// WRITE   | FB_WE held with stable address/data until FB_READY
// DONE    | one-cycle FRAME_DONE, frame counter bump, optional restart

module rt_pixel_dispatcher #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              CONTINUOUS,
    output logic              RT_ENABLE,
    output logic [X_W-1:0]    RT_X,
    output logic [Y_W-1:0]    RT_Y,
    input  logic              RT_READY,
    input  logic [PIX_W-1:0]  RT_PIXEL,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [PIX_W-1:0]  FB_DATA,
    input  logic              FB_READY,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic [CNT_W-1:0]  FRAME_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    state_t              state_q;
    state_t              state_d;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [PIX_W-1:0]    data_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                blank_q;

    logic                last_x;
    logic                last_pix;
    logic                capture;
    logic                accept;

    assign last_x   = (x_q == X_LAST);
    assign last_pix = last_x && (y_q == Y_LAST);
    // RT_READY only counts once the blanking cycle has passed
    assign capture  = (state_q == S_WAIT) && !blank_q && RT_READY;
    assign accept   = (state_q == S_WRITE) && FB_READY;

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (capture) state_d = S_WRITE;
            S_WRITE: if (accept) state_d = last_pix ? S_DONE : S_ISSUE;
            S_DONE:  state_d = CONTINUOUS ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs decoded from state
    always_comb begin
        RT_ENABLE  = (state_q == S_ISSUE);
        FB_WE      = (state_q == S_WRITE);
        BUSY       = (state_q != S_IDLE);
        FRAME_DONE = (state_q == S_DONE);
    end

    // Raster position, incremental address, captured pixel and frame counter
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        x_q    <= '0;
                        y_q    <= '0;
                        addr_q <= '0;
                    end
                end
                S_ISSUE: begin
                    blank_q <= 1'b1;
                end
                S_WAIT: begin
                    blank_q <= 1'b0;
                    if (capture) begin
                        data_q <= RT_PIXEL;
                    end
                end
                S_WRITE: begin
                    if (FB_READY) begin
                        // last pixel wraps straight to origin so Y never reaches V_RES
                        if (last_pix) begin
                            x_q    <= '0;
                            y_q    <= '0;
                            addr_q <= '0;
                        end else if (!last_x) begin
                            x_q    <= x_q + 1'b1;
                            addr_q <= addr_q + 1'b1;
                        end else begin
                            x_q    <= '0;
                            y_q    <= y_q + 1'b1;
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    cnt_q  <= cnt_q + 1'b1;
                    x_q    <= '0;
                    y_q    <= '0;
                    addr_q <= '0;
                end
                default: begin
                    blank_q <= 1'b0;
                end
            endcase
        end
    end

    assign RT_X        = x_q;
    assign RT_Y        = y_q;
    assign FB_ADDR     = addr_q;
    assign FB_DATA     = data_q;
    assign FRAME_COUNT = cnt_q;

endmodule

// File: tb/tb_rt_pixel_dispatcher.sv
// tb_rt_pixel_dispatcher
// Directed bench on a 4x3 raster with a 2-bit frame counter; an RTcore stand-in
// answers 3 cycles after ENABLE (or holds READY high) with pixel = X+Y.

module tb_rt_pixel_dispatcher;

    localparam int H_RES  = 4;
    localparam int V_RES  = 3;
    localparam int X_W    = 2;
    localparam int Y_W    = 2;
    localparam int ADDR_W = 4;
    localparam int PIX_W  = 4;
    localparam int CNT_W  = 2;

    logic              CLK;
    logic              RESET;
    logic              START;
    logic              CONTINUOUS;
    logic              RT_ENABLE;
    logic [X_W-1:0]    RT_X;
    logic [Y_W-1:0]    RT_Y;
    logic              RT_READY;
    logic [PIX_W-1:0]  RT_PIXEL;
    logic              FB_WE;
    logic [ADDR_W-1:0] FB_ADDR;
    logic [PIX_W-1:0]  FB_DATA;
    logic              FB_READY;
    logic              BUSY;
    logic              FRAME_DONE;
    logic [CNT_W-1:0]  FRAME_COUNT;

    rt_pixel_dispatcher #(
        .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W),
        .ADDR_W(ADDR_W), .PIX_W(PIX_W), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .CONTINUOUS(CONTINUOUS),
        .RT_ENABLE(RT_ENABLE), .RT_X(RT_X), .RT_Y(RT_Y),
        .RT_READY(RT_READY), .RT_PIXEL(RT_PIXEL),
        .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_READY(FB_READY),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .FRAME_COUNT(FRAME_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    // RTcore stand-in
    logic rt_const;
    int   rt_cnt;
    initial begin
        RT_READY = 1'b0;
        RT_PIXEL = '0;
        rt_cnt   = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (rt_const) begin
                RT_READY = 1'b1;
            end else if (RT_ENABLE) begin
                RT_READY = 1'b0;
                rt_cnt   = 3;
            end else if (rt_cnt > 0) begin
                rt_cnt = rt_cnt - 1;
                if (rt_cnt == 0) RT_READY = 1'b1;
            end
            RT_PIXEL = PIX_W'(RT_X) + PIX_W'(RT_Y);
        end
    end

    // Event monitor, sampled mid-cycle
    int          cyc    = 0;
    int          wr_cnt = 0;
    int          en_cnt = 0;
    int          fd_cnt = 0;
    logic [3:0]  wr_addr_log [0:255];
    logic [3:0]  wr_data_log [0:255];
    logic [1:0]  wr_y_log    [0:255];
    int          wr_cyc_log  [0:255];
    int          en_cyc_log  [0:255];

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (FB_WE && FB_READY) begin
            wr_addr_log[wr_cnt[7:0]] <= FB_ADDR;
            wr_data_log[wr_cnt[7:0]] <= FB_DATA;
            wr_y_log[wr_cnt[7:0]]    <= RT_Y;
            wr_cyc_log[wr_cnt[7:0]]  <= cyc;
            wr_cnt <= wr_cnt + 1;
        end
        if (RT_ENABLE) begin
            en_cyc_log[en_cnt[7:0]] <= cyc;
            en_cnt <= en_cnt + 1;
        end
        if (FRAME_DONE) fd_cnt <= fd_cnt + 1;
    end

    task automatic pulse_start();
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!FRAME_DONE && n < 400);
        chk(tag, FRAME_DONE, 1);
    endtask

    task automatic wait_write_at(input logic [3:0] a, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!(FB_WE && FB_ADDR == a) && n < 400);
        chk(tag, FB_WE && (FB_ADDR == a), 1);
    endtask

    initial begin
        int wb, eb, fb, bad, hits;
        RESET      = 1'b1;
        START      = 1'b0;
        CONTINUOUS = 1'b0;
        FB_READY   = 1'b1;
        rt_const   = 1'b0;

        // reset state
        #12;
        chk("rst_busy", BUSY, 0);
        chk("rst_outs", {RT_ENABLE, FB_WE, FRAME_DONE}, 0);
        chk("rst_pos", {RT_X, RT_Y, FB_ADDR, FB_DATA, FRAME_COUNT}, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // full frame, FB always ready
        wb = wr_cnt; fb = fd_cnt;
        pulse_start();
        chk("t1_busy", BUSY, 1);
        wait_done("t1_done");
        @(posedge CLK);
        #1;
        chk("t1_wr_n", wr_cnt - wb, 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t1_addr%0d", i), wr_addr_log[(wb + i) % 256], i);
            chk($sformatf("t1_data%0d", i), wr_data_log[(wb + i) % 256], (i % 4) + (i / 4));
        end
        chk("t1_fd_n", fd_cnt - fb, 1);
        chk("t1_count", FRAME_COUNT, 1);
        chk("t1_idle", BUSY, 0);

        // back-pressure on address 6
        wb = wr_cnt;
        pulse_start();
        wait_write_at(4'd6, "t2_reach6");
        FB_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("t2_hold_we", FB_WE, 1);
            chk("t2_hold_addr", FB_ADDR, 6);
            chk("t2_hold_data", FB_DATA, 3);
            chk("t2_no_en", RT_ENABLE, 0);
        end
        @(posedge CLK);
        #1;
        FB_READY = 1'b1;
        wait_done("t2_done");
        @(posedge CLK);
        #1;
        hits = 0;
        for (int i = 0; i < 12; i++) if (wr_addr_log[(wb + i) % 256] == 4'd6) hits++;
        chk("t2_wr_n", wr_cnt - wb, 12);
        chk("t2_one6", hits, 1);
        chk("t2_count", FRAME_COUNT, 2);

        // RT_READY stuck high
        rt_const = 1'b1;
        wb = wr_cnt; eb = en_cnt;
        pulse_start();
        wait_done("t3_done");
        @(posedge CLK);
        #1;
        chk("t3_en_n", en_cnt - eb, 12);
        bad = 0;
        for (int i = 0; i < 11; i++)
            if (en_cyc_log[(eb + i + 1) % 256] - en_cyc_log[(eb + i) % 256] != 4) bad++;
        chk("t3_gap4", bad, 0);
        chk("t3_lat", wr_cyc_log[wb % 256] - en_cyc_log[eb % 256], 3);
        chk("t3_data11", wr_data_log[(wb + 11) % 256], 5);
        chk("t3_data6", wr_data_log[(wb + 6) % 256], 3);
        chk("t3_count", FRAME_COUNT, 3);
        rt_const = 1'b0;
        @(posedge CLK);
        #1;

        // async reset during WRITE at address 7
        fb = fd_cnt;
        pulse_start();
        wait_write_at(4'd7, "t4_reach7");
        #2;
        RESET = 1'b1;
        #1;
        chk("t4_ctl0", {RT_ENABLE, FB_WE, FRAME_DONE, BUSY}, 0);
        chk("t4_pos0", {RT_X, RT_Y, FB_ADDR}, 0);
        chk("t4_data0", FB_DATA, 0);
        chk("t4_cnt0", FRAME_COUNT, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        chk("t4_idle", BUSY, 0);
        chk("t4_no_fd", fd_cnt - fb, 0);
        wb = wr_cnt;
        pulse_start();
        wait_done("t4_done");
        @(posedge CLK);
        #1;
        chk("t4_first0", wr_addr_log[wb % 256], 0);
        chk("t4_wr_n", wr_cnt - wb, 12);
        chk("t4_count", FRAME_COUNT, 1);

        // continuous frames, 2-bit counter wraps
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        CONTINUOUS = 1'b1;
        pulse_start();
        for (int f = 1; f <= 5; f++) begin
            if (f == 2) begin
                repeat (10) @(posedge CLK);
                #1;
                pulse_start();
            end
            wait_done($sformatf("t5_done%0d", f));
            if (f == 3) START = 1'b1;
            @(posedge CLK);
            #1;
            START = 1'b0;
            chk($sformatf("t5_count%0d", f), FRAME_COUNT, f % 4);
            chk($sformatf("t5_last_addr%0d", f), wr_addr_log[(wr_cnt - 1) % 256], 11);
            chk($sformatf("t5_last_y%0d", f), wr_y_log[(wr_cnt - 1) % 256], 2);
            if (f < 5) begin
                chk($sformatf("t5_reissue%0d", f), {RT_ENABLE, BUSY}, 2'b11);
                chk($sformatf("t5_origin%0d", f), {RT_X, RT_Y, FB_ADDR}, 0);
            end else begin
                chk("t5_stop", BUSY, 0);
            end
            if (f == 4) CONTINUOUS = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
